// File: rtl/shift_pipo_reg.sv
// Parallel-in/parallel-out shift register for the Booth A/Q operands, with
// manual shifts and a built-in N-step right-shift sequencer.
module shift_pipo_reg #(
    parameter int               WIDTH   = 16,
    parameter int               CNT_W   = $clog2(WIDTH + 1),
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] in,
    input  logic             sh_en,
    input  logic             sh_dir,
    input  logic             arith,
    input  logic             sin,
    input  logic             go,
    input  logic [CNT_W-1:0] nshift,
    output logic [WIDTH-1:0] data,
    output logic             sout,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_data;
    logic             r_sout;
    logic [CNT_W-1:0] r_cnt;

    logic             w_fill;
    logic [WIDTH-1:0] w_shr_data;
    logic [WIDTH-1:0] w_shl_data;

    function automatic logic [WIDTH-1:0] shift_right(input logic [WIDTH-1:0] d,
                                                     input logic fill);
        return {fill, d[WIDTH-1:1]};
    endfunction

    function automatic logic [WIDTH-1:0] shift_left(input logic [WIDTH-1:0] d,
                                                    input logic fill);
        return {d[WIDTH-2:0], fill};
    endfunction

    // Arithmetic fill replicates the sign bit; otherwise the serial input enters at the MSB.
    assign w_fill     = arith ? r_data[WIDTH-1] : sin;
    assign w_shr_data = shift_right(r_data, w_fill);
    assign w_shl_data = shift_left(r_data, sin);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_data  <= RST_VAL;
            r_sout  <= 1'b0;
            r_cnt   <= '0;
        end else if (clr) begin
            r_state <= S_IDLE;
            r_data  <= RST_VAL;
            r_sout  <= 1'b0;
            r_cnt   <= '0;
        end else if (ld) begin
            r_state <= S_IDLE;
            r_data  <= in;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_SHIFT: begin
                    r_data <= w_shr_data;
                    r_sout <= r_data[0];
                    r_cnt  <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    // A start request takes precedence over a manual shift in the same cycle.
                    if (go) begin
                        if (nshift == '0) begin
                            r_state <= S_DONE;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= S_SHIFT;
                            r_cnt   <= nshift;
                        end
                    end else if (sh_en) begin
                        if (sh_dir) begin
                            r_data <= w_shl_data;
                            r_sout <= r_data[WIDTH-1];
                        end else begin
                            r_data <= w_shr_data;
                            r_sout <= r_data[0];
                        end
                    end
                end
            endcase
        end
    end

    assign data = r_data;
    assign sout = r_sout;
    assign cnt  = r_cnt;
    assign busy = (r_state == S_SHIFT);
    assign done = (r_state == S_DONE);

endmodule
